// File: rtl/ps2_pkg.sv
// Shared constants, tracker state encoding and frame check for the PS/2 scan-code receiver.
// Frame on the wire: start(0), 8 data bits LSB first, odd parity, stop(1).
package ps2_pkg;

  localparam logic [7:0] PS2_BREAK      = 8'hF0;
  localparam logic [7:0] PS2_EXT        = 8'hE0;
  localparam int         PS2_FRAME_BITS = 11;

  typedef enum logic {
    TRK_IDLE,
    TRK_BREAK
  } trk_state_e;

  // shift_i holds {parity, data[7:0], start}; stop_i is the bit sampled on the final edge.
  function automatic logic frame_ok(input logic [9:0] shift_i, input logic stop_i);
    return ~shift_i[0] & stop_i & (^shift_i[9:1]);
  endfunction

endpackage

// File: rtl/ps2_fifo.sv
// Synchronous FIFO with combinational head; a pop is only honoured when non-empty,
// and a push while full succeeds only if a pop is accepted in the same cycle.
module ps2_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_i,
  input  logic [WIDTH-1:0] din_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] head_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wptr_q, wptr_d;
  logic [AW-1:0]    rptr_q, rptr_d;
  logic [AW:0]      cnt_q, cnt_d;
  logic             pop_ok, push_ok;

  assign empty_o = (cnt_q == '0);
  assign full_o  = (cnt_q == (AW+1)'(DEPTH));
  assign head_o  = mem_q[rptr_q];

  assign pop_ok  = pop_i & ~empty_o;
  assign push_ok = push_i & (~full_o | pop_ok);

  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    cnt_d  = cnt_q;
    if (push_ok) wptr_d = wptr_q + AW'(1);
    if (pop_ok)  rptr_d = rptr_q + AW'(1);
    if (push_ok && !pop_ok)      cnt_d = cnt_q + (AW+1)'(1);
    else if (!push_ok && pop_ok) cnt_d = cnt_q - (AW+1)'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      cnt_q  <= cnt_d;
      if (push_ok) mem_q[wptr_q] <= din_i;
    end
  end

endmodule

// File: rtl/ps2_scan_rx.sv
// PS/2 keyboard receiver: synchronise pins, deserialise and check frames, buffer good
// scan codes, and track make/break sequences to drive the current key code.
module ps2_scan_rx
  import ps2_pkg::*;
#(
  parameter int FIFO_DEPTH  = 8,
  parameter int TIMEOUT_CYC = 50000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  input  logic       rd_en,
  output logic [7:0] data,
  output logic       ready,
  output logic       overflow,
  output logic       frame_err,
  output logic [7:0] key_code,
  output logic       key_down,
  output logic [7:0] press_cnt
);

  localparam int         TW       = $clog2(TIMEOUT_CYC + 1);
  localparam logic [3:0] LAST_BIT = 4'(PS2_FRAME_BITS - 1);

  logic [2:0]    kclk_q;
  logic [1:0]    kdat_q;
  logic          fall, dat_s;

  logic [3:0]    bit_cnt_q, bit_cnt_d;
  logic [9:0]    shift_q, shift_d;
  logic [TW-1:0] to_cnt_q, to_cnt_d;
  logic          push_q, push_d;
  logic [7:0]    byte_q, byte_d;
  logic          ferr_q, ferr_d;
  logic          ovf_q, ovf_d;

  trk_state_e    trk_q, trk_d;
  logic [7:0]    kc_q, kc_d;
  logic          kd_q, kd_d;
  logic [7:0]    pc_q, pc_d;

  logic          fifo_full, fifo_empty, pop_ok;

  // Data uses stage 2 so it lines up with the clock edge seen between stages 2 and 3.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      kclk_q <= '1;
      kdat_q <= '1;
    end else begin
      kclk_q <= {kclk_q[1:0], ps2_clk};
      kdat_q <= {kdat_q[0], ps2_data};
    end
  end

  assign fall  = kclk_q[2] & ~kclk_q[1];
  assign dat_s = kdat_q[1];

  always_comb begin
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    to_cnt_d  = to_cnt_q;
    push_d    = 1'b0;
    byte_d    = byte_q;
    ferr_d    = 1'b0;
    if (fall) begin
      to_cnt_d = '0;
      if (bit_cnt_q == LAST_BIT) begin
        bit_cnt_d = '0;
        if (frame_ok(shift_q, dat_s)) begin
          push_d = 1'b1;
          byte_d = shift_q[8:1];
        end else begin
          ferr_d = 1'b1;
        end
      end else begin
        shift_d   = {dat_s, shift_q[9:1]};
        bit_cnt_d = bit_cnt_q + 4'd1;
      end
    end else if (bit_cnt_q != '0) begin
      if (to_cnt_q == TW'(TIMEOUT_CYC - 1)) begin
        bit_cnt_d = '0;
        to_cnt_d  = '0;
      end else begin
        to_cnt_d = to_cnt_q + TW'(1);
      end
    end
  end

  // Tracker sees every good byte, including ones the FIFO has to drop.
  always_comb begin
    trk_d = trk_q;
    kc_d  = kc_q;
    kd_d  = kd_q;
    pc_d  = pc_q;
    if (push_q) begin
      case (trk_q)
        TRK_IDLE: begin
          if (byte_q == PS2_BREAK) begin
            trk_d = TRK_BREAK;
          end else if (byte_q != PS2_EXT) begin
            if (!kd_q || byte_q != kc_q) pc_d = pc_q + 8'd1;
            kc_d = byte_q;
            kd_d = 1'b1;
          end
        end
        TRK_BREAK: begin
          if (byte_q != PS2_EXT) begin
            trk_d = TRK_IDLE;
            if (byte_q == kc_q) kd_d = 1'b0;
          end
        end
        default: trk_d = TRK_IDLE;
      endcase
    end
  end

  assign pop_ok = rd_en & ~fifo_empty;

  always_comb begin
    ovf_d = ovf_q;
    if (push_q && fifo_full && !pop_ok) ovf_d = 1'b1;
    else if (pop_ok)                    ovf_d = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bit_cnt_q <= '0;
      shift_q   <= '0;
      to_cnt_q  <= '0;
      push_q    <= 1'b0;
      byte_q    <= '0;
      ferr_q    <= 1'b0;
      ovf_q     <= 1'b0;
      trk_q     <= TRK_IDLE;
      kc_q      <= '0;
      kd_q      <= 1'b0;
      pc_q      <= '0;
    end else begin
      bit_cnt_q <= bit_cnt_d;
      shift_q   <= shift_d;
      to_cnt_q  <= to_cnt_d;
      push_q    <= push_d;
      byte_q    <= byte_d;
      ferr_q    <= ferr_d;
      ovf_q     <= ovf_d;
      trk_q     <= trk_d;
      kc_q      <= kc_d;
      kd_q      <= kd_d;
      pc_q      <= pc_d;
    end
  end

  ps2_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (8)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (push_q),
    .din_i   (byte_q),
    .pop_i   (rd_en),
    .head_o  (data),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  assign ready     = ~fifo_empty;
  assign overflow  = ovf_q;
  assign frame_err = ferr_q;
  assign key_code  = kc_q;
  assign key_down  = kd_q;
  assign press_cnt = pc_q;

endmodule
